demux_router_1x2: RTL and testbench

Registered 1-to-2 stream router: the sequential counterpart of the combinational 1x2 demux, placed directly downstream of a single valid/ready source and feeding two independent sinks. Each input packet is steered whole to output 0 or 1 according to a destination bit sampled on its first beat. Each output has its own small FIFO, so a stalled sink does not block packets bound for the other sink once the current packet completes. Per-output completed-packet counters are provided for debug.

---
 rtl/demux_router_1x2_if.sv | 38 +++
 rtl/demux_router_1x2.sv | 133 +++++++++++++
 tb/tb_demux_router_1x2.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_router_1x2_if.sv
// Stream bundle for the 1x2 router: one valid/ready input and two
// valid/ready outputs plus the per-output packet counters.
// The router takes the "slave" side (it sinks the input stream and
// drives the output streams); the environment takes the "master" side.
interface demux_router_1x2_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         in_dest;

  logic         out0_valid;
  logic         out0_ready;
  logic [W-1:0] out0_data;
  logic         out0_last;

  logic         out1_valid;
  logic         out1_ready;
  logic [W-1:0] out1_data;
  logic         out1_last;

  logic [7:0]   pkt_cnt0;
  logic [7:0]   pkt_cnt1;

  modport slave (
    input  in_valid, in_data, in_last, in_dest, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out0_last,
           out1_valid, out1_data, out1_last, pkt_cnt0, pkt_cnt1
  );

  modport master (
    output in_valid, in_data, in_last, in_dest, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out0_last,
           out1_valid, out1_data, out1_last, pkt_cnt0, pkt_cnt1
  );
endinterface

// File: rtl/demux_router_1x2.sv
// Registered 1-to-2 packet router. The destination bit is sampled on the
// first beat of each packet and locked until the last beat; every beat is
// written into a small per-output FIFO so each sink drains independently.
// Per-output counters track fully delivered packets (8-bit, wrapping).
module demux_router_1x2 #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  demux_router_1x2_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        dest_q, dest_d;
  logic        eff_dest;
  logic        accept;

  // FIFO storage entries are {data, last}; index 0 feeds out0, 1 feeds out1
  logic [W:0]  mem    [2][DEPTH];
  logic [AW:0] wr_ptr [2];
  logic [AW:0] rd_ptr [2];
  logic [W:0]  head   [2];
  logic [1:0]  full;
  logic [1:0]  empty;
  logic [1:0]  wr_en;
  logic [1:0]  rd_en;
  logic [1:0]  out_ready;
  logic [7:0]  cnt    [2];

  // FIFO status flags and head-of-queue entries
  always_comb begin
    full  = '0;
    empty = '0;
    for (int i = 0; i < 2; i++) begin
      full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                 (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      head[i]  = mem[i][rd_ptr[i][AW-1:0]];
    end
  end

  // Destination is live on a first beat, locked for the rest of the packet
  assign eff_dest     = (state_q == IDLE) ? bus.in_dest : dest_q;
  assign bus.in_ready = ~rst & ~full[eff_dest];
  assign accept       = bus.in_valid & bus.in_ready;
  assign wr_en        = {accept & eff_dest, accept & ~eff_dest};
  assign out_ready    = {bus.out1_ready, bus.out0_ready};
  assign rd_en        = ~empty & out_ready;

  assign bus.out0_valid = ~empty[0];
  assign bus.out0_data  = head[0][W:1];
  assign bus.out0_last  = head[0][0];
  assign bus.out1_valid = ~empty[1];
  assign bus.out1_data  = head[1][W:1];
  assign bus.out1_last  = head[1][0];
  assign bus.pkt_cnt0   = cnt[0];
  assign bus.pkt_cnt1   = cnt[1];

  // Packet framing: lock destination on a non-final first beat, release on last
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (!bus.in_last) begin
            state_d = ROUTE;
            dest_d  = bus.in_dest;
          end
        end
        ROUTE: begin
          if (bus.in_last) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Framing state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dest_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  // FIFO pointers and delivered-packet counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
        end
        if (rd_en[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
          if (head[i][0]) begin
            cnt[i] <= cnt[i] + 8'd1;
          end
        end
      end
    end
  end

  // FIFO storage writes; contents are not cleared by reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i]) begin
        mem[i][wr_ptr[i][AW-1:0]] <= {bus.in_data, bus.in_last};
      end
    end
  end

endmodule

// File: tb/tb_demux_router_1x2.sv
// Bench for demux_router_1x2: directed scenarios plus randomized packets.
// Expected beats are queued per output at packet level when the driver's
// beat is accepted; a negedge monitor pops and compares on every handshake.
module tb_demux_router_1x2;

  logic clk = 1'b0;
  logic rst;

  demux_router_1x2_if #(.W(8)) bus ();

  demux_router_1x2 #(.W(8), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp0[$];
  logic [8:0] exp1[$];
  int         cnt_m0   = 0;
  int         cnt_m1   = 0;
  int         acc_cnt  = 0;
  bit         rand_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: compare each delivered beat and the running counters
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("pkt_cnt0_track", 32'(bus.pkt_cnt0), 32'(cnt_m0));
      check("pkt_cnt1_track", 32'(bus.pkt_cnt1), 32'(cnt_m1));
      if (bus.out0_valid) begin
        if (exp0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out0_unexpected: valid with data 0x%0h, required no beat (t=%0t)",
                   bus.out0_data, $time);
        end else if (bus.out0_ready) begin
          logic [8:0] e;
          e = exp0.pop_front();
          check("out0_beat", {23'd0, bus.out0_data, bus.out0_last}, {23'd0, e});
          if (e[0]) cnt_m0 = (cnt_m0 + 1) % 256;
        end
      end
      if (bus.out1_valid) begin
        if (exp1.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out1_unexpected: valid with data 0x%0h, required no beat (t=%0t)",
                   bus.out1_data, $time);
        end else if (bus.out1_ready) begin
          logic [8:0] e;
          e = exp1.pop_front();
          check("out1_beat", {23'd0, bus.out1_data, bus.out1_last}, {23'd0, e});
          if (e[0]) cnt_m1 = (cnt_m1 + 1) % 256;
        end
      end
    end
  end

  // Random sink backpressure, active only during the random phase
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) begin
        bus.out0_ready = ($urandom_range(0, 3) != 0);
        bus.out1_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Offer one beat until accepted; mdest is the packet's destination
  task automatic send_beat(input bit mdest, input logic [7:0] d, input bit l, input bit idest);
    int  t;
    bit  rdy;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_dest  = idest;
    forever begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        if (mdest) exp1.push_back({d, l});
        else       exp0.push_back({d, l});
        acc_cnt++;
        #1;
        break;
      end
      #1;
      t++;
      if (t > 300) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: beat 0x%0h not accepted, required acceptance within 300 cycles", d);
        bus.in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset(input int n, input bit keep_valid);
    rst = 1'b1;
    if (!keep_valid) bus.in_valid = 1'b0;
    exp0.delete();
    exp1.delete();
    cnt_m0 = 0;
    cnt_m1 = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
      check("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
      check("rst_pkt_cnt0", 32'(bus.pkt_cnt0), 32'd0);
      check("rst_pkt_cnt1", 32'(bus.pkt_cnt1), 32'd0);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (exp0.size() == 0 && exp1.size() == 0 && !bus.out0_valid && !bus.out1_valid) break;
      t++;
      if (t > 3000) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain_timeout: %0d/%0d beats still pending, required 0/0",
                 exp0.size(), exp1.size());
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_data    = 8'h00;
    bus.in_last    = 1'b1;
    bus.in_dest    = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;

    // Reset values with in_valid held high
    do_reset(3, 1'b1);

    // Routing and destination lock
    send_beat(1'b1, 8'h11, 1'b0, 1'b1);
    check("route_b1_valid", 32'(bus.out1_valid), 32'd1);
    check("route_b1_data", 32'(bus.out1_data), 32'h11);
    check("route_b1_last", 32'(bus.out1_last), 32'd0);
    send_beat(1'b1, 8'h22, 1'b0, 1'b0);
    check("route_b2_valid", 32'(bus.out1_valid), 32'd1);
    check("route_b2_data", 32'(bus.out1_data), 32'h22);
    check("route_b2_out0", 32'(bus.out0_valid), 32'd0);
    send_beat(1'b1, 8'h33, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    check("route_b3_data", 32'(bus.out1_data), 32'h33);
    check("route_b3_last", 32'(bus.out1_last), 32'd1);
    check("route_b3_out0", 32'(bus.out0_valid), 32'd0);
    wait_drain();
    check("route_pkt_cnt1", 32'(bus.pkt_cnt1), 32'd1);

    // Backpressure into a full FIFO, then release
    bus.out0_ready = 1'b0;
    acc_cnt = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_beat(1'b0, 8'hA0 + 8'(i), (i == 3), 1'b0);
        bus.in_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 100 && acc_cnt < 2; t++) begin
          @(posedge clk);
          #1;
        end
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        check("bp_accepted", 32'(acc_cnt), 32'd2);
        check("bp_head", 32'(bus.out0_data), 32'hA0);
        @(posedge clk);
        #1;
        bus.out0_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_pkt_cnt0", 32'(bus.pkt_cnt0), 32'd1);

    // Independent paths: out1 stalled and full, out0 still flows
    bus.out1_ready = 1'b0;
    send_beat(1'b1, 8'hB1, 1'b1, 1'b1);
    send_beat(1'b1, 8'hB2, 1'b1, 1'b1);
    send_beat(1'b0, 8'h5C, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    check("ind_out0_valid", 32'(bus.out0_valid), 32'd1);
    check("ind_out0_data", 32'(bus.out0_data), 32'h5C);
    bus.in_dest = 1'b1;
    #1;
    check("ind_hol_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("ind_out1_held_valid", 32'(bus.out1_valid), 32'd1);
      check("ind_out1_held_data", 32'(bus.out1_data), 32'hB1);
    end
    @(posedge clk);
    #1;
    check("ind_out0_drained", 32'(bus.out0_valid), 32'd0);
    bus.out1_ready = 1'b1;
    wait_drain();
    check("ind_pkt_cnt0", 32'(bus.pkt_cnt0), 32'd2);
    check("ind_pkt_cnt1", 32'(bus.pkt_cnt1), 32'd3);

    // Randomized packets with random gaps, dest toggling and sink stalls
    rand_rdy = 1'b1;
    for (int p = 0; p < 150; p++) begin
      int len;
      bit dst;
      len = $urandom_range(1, 4);
      dst = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        send_beat(dst, 8'($urandom), (i == len - 1),
                  (i == 0) ? dst : 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) begin
          bus.in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      bus.in_valid = 1'b0;
    end
    rand_rdy = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    wait_drain();

    // Counter wrap on out1
    do_reset(1, 1'b0);
    for (int p = 0; p < 255; p++) send_beat(1'b1, 8'($urandom), 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    wait_drain();
    check("wrap_cnt1_255", 32'(bus.pkt_cnt1), 32'd255);
    send_beat(1'b1, 8'h99, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    wait_drain();
    check("wrap_cnt1_0", 32'(bus.pkt_cnt1), 32'd0);
    check("wrap_cnt0_0", 32'(bus.pkt_cnt0), 32'd0);

    // Reset mid-packet discards partial contents and reframes
    bus.out1_ready = 1'b0;
    send_beat(1'b1, 8'h61, 1'b0, 1'b1);
    send_beat(1'b1, 8'h62, 1'b0, 1'b1);
    check("mid_out1_filled", 32'(bus.out1_valid), 32'd1);
    do_reset(1, 1'b0);
    bus.out1_ready = 1'b1;
    send_beat(1'b0, 8'h7E, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    check("mid_out0_valid", 32'(bus.out0_valid), 32'd1);
    check("mid_out0_data", 32'(bus.out0_data), 32'h7E);
    check("mid_out1_empty", 32'(bus.out1_valid), 32'd0);
    wait_drain();
    check("mid_pkt_cnt0", 32'(bus.pkt_cnt0), 32'd1);
    check("mid_pkt_cnt1", 32'(bus.pkt_cnt1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
